reg_file_mp: RTL and testbench



---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_clear_seq.sv | 77 +++++++
 rtl/reg_file_mp.sv | 99 +++++++++
 tb/tb_reg_file_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
//   clr_state_e : clear sequencer state encoding
//   rf_depth()  : number of entries for a given address width
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  function automatic int unsigned rf_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/reg_file_clear_seq.sv
// Clear sequencer for reg_file_mp: after reset, or on a clear request while
// idle, sweeps every entry writing zero, one entry per cycle.
// Ports:
//   clk        in   clock
//   reset_n    in   synchronous active-low reset (restarts the sweep)
//   clear_i    in   clear request, sampled only while idle
//   ready_o    out  1 = idle, user writes accepted
//   clr_we_o   out  clear write strobe to the array
//   clr_addr_o out  entry being cleared this cycle
//
// state    | meaning
// ---------+----------------------------------------------
// ST_CLEAR | zeroing entry[cnt_q], advancing once a cycle
// ST_IDLE  | sweep done, array open to user writes
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned addr_width_p = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear_i,
  output logic                    ready_o,
  output logic                    clr_we_o,
  output logic [addr_width_p-1:0] clr_addr_o
);

  clr_state_e              state_q, state_d;
  logic [addr_width_p-1:0] cnt_q, cnt_d;
  logic                    ready_q, ready_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    clr_we_o = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        // Counter wraps from all-ones back to zero on the same edge we leave.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign ready_o    = ready_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file: two write ports (port 1 wins on an
// address collision), num_rd_p combinational read ports, optional hardwired
// zero entry and a hardware clear sweep after reset or on request.
// Optional feature macro: REG_FILE_BYPASS_EN -- same-cycle write-to-read
// forwarding while idle.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   clear_i / ready_o      clear request / sequencer idle
//   rd_addr_i / rd_data_o  packed read ports, port k at slice k
//   wen0_i, waddr0_i, wdata0_i  write port 0
//   wen1_i, waddr1_i, wdata1_i  write port 1 (higher priority)
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned data_width_p = 32,
  parameter int unsigned addr_width_p = 6,
  parameter int unsigned num_rd_p     = 2,
  parameter int unsigned zero_reg_p   = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear_i,
  output logic                             ready_o,
  input  logic [num_rd_p*addr_width_p-1:0] rd_addr_i,
  output logic [num_rd_p*data_width_p-1:0] rd_data_o,
  input  logic                             wen0_i,
  input  logic [addr_width_p-1:0]          waddr0_i,
  input  logic [data_width_p-1:0]          wdata0_i,
  input  logic                             wen1_i,
  input  logic [addr_width_p-1:0]          waddr1_i,
  input  logic [data_width_p-1:0]          wdata1_i
);

  localparam int unsigned depth_lp = rf_depth(addr_width_p);

  logic [data_width_p-1:0] mem_q [depth_lp];

  logic                    clr_we;
  logic [addr_width_p-1:0] clr_addr;
  logic                    wr_ok;
  logic                    we0_ok, we1_ok;

  reg_file_clear_seq #(
    .addr_width_p (addr_width_p)
  ) u_clear_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear_i),
    .ready_o    (ready_o),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // User writes only in idle and never while reset is held.
  assign wr_ok  = ready_o && reset_n;
  assign we0_ok = wen0_i && wr_ok && !(zero_reg_p != 0 && waddr0_i == '0);
  assign we1_ok = wen1_i && wr_ok && !(zero_reg_p != 0 && waddr1_i == '0);

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (we0_ok && !(we1_ok && waddr1_i == waddr0_i)) begin
        mem_q[waddr0_i] <= wdata0_i;
      end
      if (we1_ok) begin
        mem_q[waddr1_i] <= wdata1_i;
      end
    end
  end

  for (genvar k = 0; k < num_rd_p; k++) begin : g_rd
    logic [addr_width_p-1:0] ra;
    logic [data_width_p-1:0] rv;

    assign ra = rd_addr_i[k*addr_width_p +: addr_width_p];

    always_comb begin
      rv = mem_q[ra];
`ifdef REG_FILE_BYPASS_EN
      if (we1_ok && waddr1_i == ra) begin
        rv = wdata1_i;
      end else if (we0_ok && waddr0_i == ra) begin
        rv = wdata0_i;
      end
`endif
      // Array contents are not trustworthy until the sweep finishes.
      if (!ready_o) begin
        rv = '0;
      end
      if (zero_reg_p != 0 && ra == '0) begin
        rv = '0;
      end
    end

    assign rd_data_o[k*data_width_p +: data_width_p] = rv;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_i;
  logic        ready, ready_z;
  logic [11:0] rd_addr;
  logic [63:0] rd_data, rd_data_z;
  logic        wen0, wen1;
  logic [5:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.data_width_p(32), .addr_width_p(6), .num_rd_p(2), .zero_reg_p(0)) dut (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .ready_o(ready),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1)
  );

  reg_file_mp #(.data_width_p(32), .addr_width_p(6), .num_rd_p(2), .zero_reg_p(1)) dut_z (
    .clk(clk), .reset_n(reset_n), .clear_i(clear_i), .ready_o(ready_z),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_z),
    .wen0_i(wen0), .waddr0_i(waddr0), .wdata0_i(wdata0),
    .wen1_i(wen1), .waddr1_i(waddr1), .wdata1_i(wdata1)
  );

  typedef struct {
    logic        w0; logic [5:0] a0; logic [31:0] d0;
    logic        w1; logic [5:0] a1; logic [31:0] d1;
    logic [5:0]  ra0; logic [31:0] e0;
    logic [5:0]  ra1; logic [31:0] e1;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 200);
  endtask

  task automatic count_nonzero(output int nz);
    nz = 0;
    for (int a = 0; a < 64; a++) begin
      rd_addr[5:0] = 6'(a);
      #1;
      if (rd_data[31:0] !== 32'h0) nz++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nz;
    logic [31:0] exp_same;

    vecs[0] = '{1'b1, 6'd7,  32'h0BADF00D, 1'b0, 6'd0, 32'h0,  6'd7,  32'h0BADF00D, 6'd6, 32'h0};
    vecs[1] = '{1'b1, 6'd9,  32'h11,       1'b1, 6'd9, 32'h22, 6'd9,  32'h22,       6'd5, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 6'd3,  32'h33,       1'b1, 6'd4, 32'h44, 6'd3,  32'h33,       6'd4, 32'h44};
    vecs[3] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd5, 32'h55, 6'd5,  32'h55,       6'd9, 32'h22};
    vecs[4] = '{1'b1, 6'd63, 32'hA5A5A5A5, 1'b0, 6'd1, 32'h1,  6'd63, 32'hA5A5A5A5, 6'd1, 32'h0};
    vecs[5] = '{1'b0, 6'd3,  32'h77,       1'b0, 6'd4, 32'h88, 6'd3,  32'h33,       6'd4, 32'h44};

    reset_n = 1'b0; clear_i = 1'b0; rd_addr = '0;
    wen0 = 1'b0; wen1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset, then the initial sweep.
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", {31'b0, ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(n);
    check("init_sweep_cycles", n, 32'd64);
    count_nonzero(nz);
    check("init_all_zero", nz, 32'd0);

    // Basic write with same-cycle read.
    @(negedge clk);
    wen0 = 1'b1; waddr0 = 6'd5; wdata0 = 32'hDEADBEEF;
    rd_addr = {6'd0, 6'd5};
    #1;
`ifdef REG_FILE_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    check("same_cycle_a5", rd_data[31:0], exp_same);
    @(negedge clk);
    wen0 = 1'b0;
    #1;
    check("next_cycle_a5", rd_data[31:0], 32'hDEADBEEF);

    // Table-driven writes and reads.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wen0 = vecs[i].w0; waddr0 = vecs[i].a0; wdata0 = vecs[i].d0;
      wen1 = vecs[i].w1; waddr1 = vecs[i].a1; wdata1 = vecs[i].d1;
      @(negedge clk);
      wen0 = 1'b0; wen1 = 1'b0;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_port0", i), rd_data[31:0],  vecs[i].e0);
      check($sformatf("vec%0d_port1", i), rd_data[63:32], vecs[i].e1);
    end

    // Zero register: write all-ones to address 0 on both instances.
    @(negedge clk);
    wen1 = 1'b1; waddr1 = 6'd0; wdata1 = 32'hFFFFFFFF;
    rd_addr = {6'd0, 6'd0};
    #1;
    check("zero_same_cycle", rd_data_z[31:0], 32'h0);
`ifdef REG_FILE_BYPASS_EN
    exp_same = 32'hFFFFFFFF;
`else
    exp_same = 32'h0;
`endif
    check("nozero_same_cycle", rd_data[31:0], exp_same);
    @(negedge clk);
    wen1 = 1'b0;
    #1;
    check("zero_reg_a0", rd_data_z[63:32], 32'h0);
    check("nozero_reg_a0", rd_data[63:32], 32'hFFFFFFFF);

    // Fill 1..63 with index values, then request a clear.
    for (int a = 1; a < 64; a++) begin
      @(negedge clk);
      wen0 = 1'b1; waddr0 = 6'(a); wdata0 = 32'(a);
    end
    @(negedge clk);
    wen0 = 1'b0;
    rd_addr = {6'd63, 6'd10};
    #1;
    check("fill_a10", rd_data[31:0], 32'd10);
    check("fill_a63", rd_data[63:32], 32'd63);
    clear_i = 1'b1;
    @(posedge clk); #1;
    check("ready_after_clear_req", {31'b0, ready}, 32'd0);
    // Writes and further clear requests during the sweep must be ignored.
    wen0 = 1'b1; waddr0 = 6'd63; wdata0 = 32'h1234;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 10) check("read_during_clear", rd_data[31:0], 32'h0);
    end while (!ready && n < 200);
    wen0 = 1'b0; clear_i = 1'b0;
    check("clear_sweep_cycles", n, 32'd64);
    count_nonzero(nz);
    check("clear_all_zero", nz, 32'd0);
    @(posedge clk); #1;
    check("ready_stays_high", {31'b0, ready}, 32'd1);

    // Reset in the middle of a sweep.
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    repeat (30) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("ready_midclear_reset", {31'b0, ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(n);
    check("restart_sweep_cycles", n, 32'd64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
